// File: rtl/n163_snd_writer.sv
// n163_snd_writer: queues sound-RAM byte writes and replays them onto the
// mapper CPU bus as $F800 address-port and $4800 data-port cycles.
// The address cycle is skipped whenever the chip's auto-incremented pointer
// already points at the requested byte.
// Ports:
//   clk, reset_n              single clock, asynchronous active-low reset
//   ce                        one-clk pulse per CPU (M2) cycle
//   sync                      one-clk pulse, forgets the tracked pointer
//   req_valid/req_ready       request handshake; req_addr (7b), req_data (8b)
//   bus_ain/bus_dout/bus_write registered CPU-side bus toward the mapper
//   done                      one-clk pulse per completed data write
//   busy                      work queued or a bus transfer in flight

// Generic synchronous FIFO with a combinational head.
// Latency: an entry is visible at the head one clk after its push.
// Backpressure: full blocks push, empty ignores pop; push and pop may share a clk.
module n163_snd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty,
  output logic             full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign head_dat = mem[rd_ptr];

  // Storage needs no reset: nothing reads it until count says it is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// Sound-RAM write sequencer: FIFO of requests feeding an IDLE/ADDR/DATA bus FSM.
// Latency: first bus cycle on the first ce after acceptance; one ce period per bus cycle.
// Backpressure: req_ready drops while the FIFO is full; without ce nothing drains.
module n163_snd_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int AUTOINC    = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        sync,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_addr,
  input  logic [7:0]  req_data,
  output logic [15:0] bus_ain,
  output logic [7:0]  bus_dout,
  output logic        bus_write,
  output logic        done,
  output logic        busy
);
  localparam logic        AI        = 1'(AUTOINC);
  localparam logic [15:0] ADDR_PORT = 16'hF800;
  localparam logic [15:0] DATA_PORT = 16'h4800;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t      state;
  logic [6:0]  cur_addr;
  logic [7:0]  cur_data;
  logic [6:0]  ptr;
  logic        ptr_valid;

  logic [14:0] head_dat;
  logic [6:0]  head_addr;
  logic [7:0]  head_data;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic [6:0]  ptr_next;
  logic        ptr_valid_next;
  logic        hit;

  assign req_ready = ~fifo_full;
  assign push      = req_valid & ~fifo_full;
  assign busy      = ~fifo_empty | (state != S_IDLE);
  assign head_addr = head_dat[14:8];
  assign head_data = head_dat[7:0];

  // The head is consumed on the same ce that ends IDLE or a DATA cycle.
  assign pop = ce & ~fifo_empty & ((state == S_IDLE) | (state == S_DATA));

  n163_snd_fifo #(
    .WIDTH (15),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_dat ({req_addr, req_data}),
    .pop      (pop),
    .head_dat (head_dat),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // Pointer as the chip will see it after this edge. A completing data write
  // advances it (7-bit wrap), and the skip decision for the next entry uses the
  // advanced value. sync is folded in last so it beats a coincident completion.
  always_comb begin
    ptr_next       = ptr;
    ptr_valid_next = ptr_valid;
    if (ce && state == S_DATA) begin
      ptr_next       = cur_addr + 7'd1;
      ptr_valid_next = AI;
    end
    if (sync) ptr_valid_next = 1'b0;
  end

  assign hit = ptr_valid_next & (head_addr == ptr_next);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cur_addr  <= '0;
      cur_data  <= '0;
      ptr       <= '0;
      ptr_valid <= 1'b0;
      bus_ain   <= '0;
      bus_dout  <= '0;
      bus_write <= 1'b0;
      done      <= 1'b0;
    end else begin
      done      <= 1'b0;
      ptr       <= ptr_next;
      ptr_valid <= ptr_valid_next;
      if (ce) begin
        case (state)
          S_ADDR: begin
            state     <= S_DATA;
            bus_ain   <= DATA_PORT;
            bus_dout  <= cur_data;
            bus_write <= 1'b1;
          end
          S_IDLE, S_DATA: begin
            if (state == S_DATA) done <= 1'b1;
            if (!fifo_empty) begin
              cur_addr  <= head_addr;
              cur_data  <= head_data;
              bus_write <= 1'b1;
              if (hit) begin
                state    <= S_DATA;
                bus_ain  <= DATA_PORT;
                bus_dout <= head_data;
              end else begin
                state    <= S_ADDR;
                bus_ain  <= ADDR_PORT;
                bus_dout <= {AI, head_addr};
              end
            end else begin
              // Park the bus so the $4800 window is never held past one ce period.
              state     <= S_IDLE;
              bus_ain   <= '0;
              bus_dout  <= '0;
              bus_write <= 1'b0;
            end
          end
          default: begin
            state     <= S_IDLE;
            bus_ain   <= '0;
            bus_dout  <= '0;
            bus_write <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: doc/n163_snd_writer.md
N163_SND_WRITER -- requirements
Module: n163_snd_writer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, request FIFO entries (power of 2, ≥2).
REQ-002 SHALL have parameter AUTOINC, default 1; when 1, address-port writes set bit 7 and consecutive addresses are burst.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 ce  input  1  one-clk pulse per CPU (M2) cycle; all bus state advances only on clk edges with ce=1.
REQ-006 sync  input  1  one-clk pulse; invalidates the tracked sound-RAM pointer.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  FIFO not full; a request is accepted on any clk edge with req_valid & req_ready.
REQ-009 req_addr  input  7  sound-RAM byte address.
REQ-010 req_data  input  8  byte to write.
REQ-011 bus_ain  output  16  CPU-side address to mapper.
REQ-012 bus_dout  output  8  CPU-side write data to mapper.
REQ-013 bus_write  output  1  write strobe to mapper.
REQ-014 done  output  1  one-clk pulse when a data write completes.
REQ-015 busy  output  1  FIFO non-empty or FSM not IDLE.

Function
REQ-016 bus_ain, bus_dout, bus_write, done SHALL be registered; bus outputs change only on ce edges and are held for one full ce period (sampled by the mapper at the next ce).
REQ-017 FSM states SHALL be IDLE, ADDR, DATA.
REQ-018 IDLE: on ce with FIFO non-empty, pop head; go DATA if pointer valid and head.addr == ptr, else ADDR; with FIFO empty stay IDLE.
REQ-019 ADDR bus cycle SHALL drive bus_ain=16'hF800, bus_dout={AUTOINC[0], addr}, bus_write=1; next ce go DATA.
REQ-020 DATA bus cycle SHALL drive bus_ain=16'h4800, bus_dout=data, bus_write=1; on next ce pulse done, set ptr=addr+1 (7-bit, 7F wraps to 00) and ptr_valid=AUTOINC, then pop next entry directly into ADDR/DATA per REQ-018 or return IDLE.
REQ-021 Outside ADDR/DATA cycles bus_ain SHALL be 16'h0000, bus_dout 8'h00, bus_write 0, so the $4800-$4FFF window is never held longer than one ce period.
REQ-022 Back-to-back matching addresses SHALL issue one DATA cycle per byte, no idle ce between them.
REQ-023 AUTOINC=0: ptr_valid never set; every request costs ADDR+DATA.
REQ-024 sync SHALL clear ptr_valid on its clk edge; if coincident with a DATA completion, clear wins.
REQ-025 FIFO push and pop in the same clk SHALL both occur; occupancy unchanged; pushing when full is blocked by req_ready=0.
REQ-026 Requests SHALL be issued in acceptance order; no reordering or merging.
REQ-027 ce absent: FSM, bus outputs and ptr SHALL hold indefinitely; FIFO still accepts pushes.
REQ-028 done SHALL be 0 in every clk other than the DATA-completion clk.

Reset
REQ-029 reset_n=0 SHALL asynchronously force: FSM IDLE, FIFO empty, ptr=0, ptr_valid=0, bus_ain=0, bus_dout=0, bus_write=0, done=0, busy=0, req_ready=1.
REQ-030 Reset mid ADDR/DATA SHALL abandon the transfer; bus_write drops immediately; FIFO contents discarded.
REQ-031 Release SHALL take effect at the first clk edge after reset_n rises; first bus cycle no earlier than the first ce after release.

Verification
REQ-032 Single write addr 0x40 data 0x5A, ce every 3 clk -> F800/0xC0 then 4800/0x5A on consecutive ce periods, one done, busy falls after.
REQ-033 Burst addrs 0x10,0x11,0x12 data A,B,C -> one F800/0x90 then three 4800 cycles, no gaps, three done pulses.
REQ-034 Addr 0x7F then 0x00 -> second write skips ADDR (wrap); addr 0x7F then 0x05 -> second write reissues F800/0x85.
REQ-035 sync between writes to 0x20 and 0x21 -> F800/0xA1 reissued before second data.
REQ-036 Push 5 with FIFO_DEPTH=4 and ce held low -> req_ready=0 after 4, fifth accepted after first pop; output order preserved.
REQ-037 reset_n low during DATA of a 3-entry burst -> bus_write=0 with no clk edge, after release busy=0 and no further bus writes.
